tick_rate_selector: RTL
=======================

Name: tick_rate_selector

Overview:
- Parametrised successor of the fixed four-clock rate multiplexer.
- Generates NUM_CH binary-related tick rates from the single system clock with one prescaler, instead of routing several derived clocks.
- Selects one rate at a time. Rate changes take effect only on a tick boundary of the current channel, so there are no truncated periods.
- Drives LED blinkers and counters in the exercise designs as a clock enable (tick_out) plus a 50% square wave (clk_out).

Parameters:
DIV_BASE, 3125000, system-clock cycles per tick of the fastest channel (16 Hz at 50 MHz); must be >= 2
NUM_CH, 5, number of rate channels, 2..8; channel i period = DIV_BASE << (NUM_CH-1-i) cycles (channel NUM_CH-1 fastest)
SEL_W, 3, width of selection ports; 2^SEL_W >= NUM_CH
RESET_SEL, 0, channel selected after reset; must be < NUM_CH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
sel_load  in  1  one-cycle request: target channel = sel_in
sel_in  in  SEL_W  requested channel; values >= NUM_CH clamp to NUM_CH-1
sel_next  in  1  one-cycle request: target = next channel, wrapping NUM_CH-1 -> 0
tick_out  out  1  one-cycle enable pulse at the selected rate
clk_out  out  1  square wave; toggles on each tick_out, so frequency = tick rate / 2
sel_cur  out  SEL_W  channel currently driving tick_out
switch_pending  out  1  high while a requested change waits for a tick boundary

Behaviour:
- Reset (rst=1 at an edge) sets: pre_cnt=0, stage counter stg=0, sel_cur=RESET_SEL, target=RESET_SEL, switch_pending=0, tick_out=0, clk_out=0. Reset wins over every other input and aborts any pending switch.
- Prescaler: pre_cnt counts 0..DIV_BASE-1 and wraps. base_tick = (pre_cnt==DIV_BASE-1), combinational.
- Stage counter: stg is NUM_CH-1 bits and increments on base_tick, wrapping freely.
- Channel raw tick: raw[i] = base_tick AND the low (NUM_CH-1-i) bits of stg are all 1. Channel NUM_CH-1 therefore ticks on every base_tick.
- Output timing: tick_out is registered, so tick_out=1 on the edge after raw[sel_cur] and for exactly one cycle. clk_out toggles on that same edge.
- Timing numbers: with edge n = n-th edge after reset release, channel i tick_out first goes high after edge period_i, then every period_i cycles.
- Requests (applied at the edge where sampled):
  - sel_load: target = clamp(sel_in).
  - else sel_next: target = (target+1) mod NUM_CH. When pending, this increments the pending target, not sel_cur.
  - sel_load together with sel_next: sel_load wins.
  - Requesting target == sel_cur with nothing pending: no-op, switch_pending stays 0.
  - A request that sets target back to sel_cur while pending: cancels, switch_pending=0 next edge.
  - switch_pending = (target != sel_cur), registered.
- Switch commit:
  - At the edge where raw[sel_cur]=1 and target != sel_cur, tick_out pulses (the final tick of the old channel) and sel_cur <= target.
  - The new channel's ticks follow its own raw schedule; the prescaler and stg are never reset by a switch.
  - Consequence: the first new-channel interval after a switch may be shorter than its nominal period, but is never zero-length. No two tick_out pulses are ever adjacent unless DIV_BASE==1 (disallowed).
- A request arriving in the same cycle as raw[sel_cur] commits only at the next tick of the current channel, because target updates at that edge and the comparison uses registered target.
- Arithmetic: pre_cnt width = clog2(DIV_BASE). All counters are unsigned with natural wrap; no overflow flags.

Test Plan:
1. DIV_BASE=4, NUM_CH=4, RESET_SEL=3, release rst -> tick_out high after edges 4,8,12,16; clk_out toggles 0->1 at 4, 1->0 at 8; sel_cur=3, switch_pending=0.
2. Same config, RESET_SEL=0 -> tick_out only after edges 32,64; channel 1 (loaded before edge 1 commits? no, via reset of RESET_SEL=1) ticks after 16,32; channel 2 after 8,16.
3. RESET_SEL=0, sel_load=1 with sel_in=3 at edge 5 -> switch_pending=1 from edge 5 until the edge-32 tick. sel_cur=3 after edge 32. Next tick_out after edge 36.
4. RESET_SEL=3, sel_next pulses at edges 2, 3, 5 -> target 0, 1, 2. Commit at the edge-4 tick sees target 1 (sel_cur=1). The later request to 2 commits at the edge-16 tick. sel_in=7 load -> sel_cur becomes 3 (clamp).
5. sel_load (sel_in=2) and sel_next asserted together from target 0 -> target=2. Then sel_load sel_in=sel_cur while pending -> switch_pending drops next edge and no switch occurs.
6. Assert rst for one edge while switch_pending=1 mid-period -> all outputs return to reset values on that edge. Tick schedule restarts as in scenario 1 or 2.

Source files
------------

// File: rtl/tick_rate_selector.sv
// tick_rate_selector: one prescaler plus a binary stage counter produce NUM_CH
// related tick rates. One rate is selected at a time. A new selection takes
// effect only on a tick of the channel currently selected, so no period is
// ever truncated. Outputs are a one-cycle enable (tick_out) and a square wave
// (clk_out) that toggles on every tick.
//
// Request semantics: sel_load and sel_next are single-cycle strobes with no
// ready. Each strobe is accepted at the edge where it is sampled high and
// updates the target channel. sel_load has priority over sel_next. The
// switch_pending output stays high while the target differs from sel_cur.
module tick_rate_selector #(
  parameter int DIV_BASE  = 3125000,
  parameter int NUM_CH    = 5,
  parameter int SEL_W     = 3,
  parameter int RESET_SEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_next,
  output logic             tick_out,
  output logic             clk_out,
  output logic [SEL_W-1:0] sel_cur,
  output logic             switch_pending
);

  localparam int PW   = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
  localparam int SW   = NUM_CH - 1;
  localparam int NSEL = 1 << SEL_W;

  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV_BASE - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] CH_RESET = SEL_W'(RESET_SEL);

  logic [PW-1:0]    pre_cnt;
  logic [SW-1:0]    stg;
  logic             base_tick;
  logic [NSEL-1:0]  raw;
  logic             cur_tick;
  logic [SEL_W-1:0] target;
  logic [SEL_W-1:0] sel_clamped;
  logic [SEL_W-1:0] target_nxt;
  logic [SEL_W-1:0] sel_cur_nxt;

  // Mask of the low k stage bits. When k equals SW, the shift yields 0 and
  // the subtraction wraps to all ones, which is the slowest channel's mask.
  function automatic logic [SW-1:0] low_mask(input int k);
    low_mask = (SW'(1) << k) - SW'(1);
  endfunction

  // Fastest-rate strobe taken from the prescaler.
  always_comb begin
    base_tick = (pre_cnt == PRE_LAST);
  end

  // Per-channel raw ticks. Unused selector codes never tick.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i] = base_tick && ((stg & low_mask(NUM_CH - 1 - i)) == low_mask(NUM_CH - 1 - i));
    end
  end

  // Tick of the selected channel. A switch may commit only on this tick.
  always_comb begin
    cur_tick = raw[sel_cur];
  end

  // Next target channel from the request strobes. Out-of-range loads clamp.
  always_comb begin
    sel_clamped = (sel_in > CH_LAST) ? CH_LAST : sel_in;
    target_nxt  = target;
    if (sel_load) begin
      target_nxt = sel_clamped;
    end else if (sel_next) begin
      target_nxt = (target == CH_LAST) ? '0 : target + 1'b1;
    end
  end

  // The switch commits on the old channel's tick and uses the registered target.
  always_comb begin
    sel_cur_nxt = (cur_tick && (target != sel_cur)) ? target : sel_cur;
  end

  // All state: prescaler, stage counter, selection, and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt        <= '0;
      stg            <= '0;
      target         <= CH_RESET;
      sel_cur        <= CH_RESET;
      switch_pending <= 1'b0;
      tick_out       <= 1'b0;
      clk_out        <= 1'b0;
    end else begin
      pre_cnt        <= base_tick ? '0 : pre_cnt + 1'b1;
      if (base_tick) begin
        stg <= stg + 1'b1;
      end
      target         <= target_nxt;
      sel_cur        <= sel_cur_nxt;
      switch_pending <= (target_nxt != sel_cur_nxt);
      tick_out       <= cur_tick;
      if (cur_tick) begin
        clk_out <= ~clk_out;
      end
    end
  end

endmodule
